// File: rtl/rom_read_arbiter_if.sv
// One requester's read channel into the ROM arbiter.
// master = requester side, slave = arbiter side.
interface rom_read_arbiter_if;
  logic        req;
  logic [9:0]  addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/rom_read_arbiter.sv
// Two-port read arbiter/sequencer for a single-port 1024x32 ROM with READ_LAT latency.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins); default is round-robin.

module rom_read_arbiter_rsp #(
  parameter int DW = 32
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          cap,
  input  logic [DW-1:0] din,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rvalid_d = cap;
    rdata_d  = cap ? din : rdata_q;
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

module rom_read_arbiter #(
  parameter int READ_LAT = 1
) (
  input  logic                clka,
  input  logic                rst,
  rom_read_arbiter_if.slave   m0,
  rom_read_arbiter_if.slave   m1,
  output logic                rom_ena,
  output logic [9:0]          rom_addra,
  input  logic [31:0]         rom_douta
);
  localparam int NUM_PORTS = 2;
  localparam int AW        = 10;
  localparam int DW        = 32;

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
  } rd_req_t;

  rd_req_t [NUM_PORTS-1:0]          req_s;
  logic    [NUM_PORTS-1:0]          rvalid_v;
  logic    [NUM_PORTS-1:0][DW-1:0]  rdata_v;
  logic                             gnt_vld, gnt_id, pref;

  assign req_s[0] = {m0.req, m0.addr};
  assign req_s[1] = {m1.req, m1.addr};

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign pref = 1'b0;
`else
  logic prio_q, prio_d;

  // The loser of any grant becomes preferred next; idle cycles keep the order.
  always_comb begin
    prio_d = prio_q;
    if (gnt_vld) prio_d = ~gnt_id;
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) prio_q <= 1'b0;
    else     prio_q <= prio_d;
  end

  assign pref = prio_q;
`endif

  // Grant is masked during reset so every output is quiet while rst is high.
  always_comb begin
    gnt_vld   = (req_s[0].req | req_s[1].req) & ~rst;
    gnt_id    = (req_s[0].req & req_s[1].req) ? pref : req_s[1].req;
    rom_ena   = gnt_vld;
    rom_addra = gnt_vld ? req_s[gnt_id].addr : '0;
  end

  assign m0.gnt = gnt_vld & ~gnt_id;
  assign m1.gnt = gnt_vld &  gnt_id;

  logic [READ_LAT-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LAT-1:0] id_pipe_q,  id_pipe_d;

  always_comb begin
    vld_pipe_d    = '0;
    id_pipe_d     = '0;
    vld_pipe_d[0] = rom_ena;
    id_pipe_d[0]  = gnt_id;
    for (int i = 1; i < READ_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      id_pipe_d[i]  = id_pipe_q[i-1];
    end
  end

  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  // Last tag stage lines up with valid rom_douta; route it to its owner.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
    logic cap;
    assign cap = vld_pipe_q[READ_LAT-1] & (id_pipe_q[READ_LAT-1] == 1'(p));
    rom_read_arbiter_rsp #(.DW(DW)) u_rsp (
      .clka   (clka),
      .rst    (rst),
      .cap    (cap),
      .din    (rom_douta),
      .rvalid (rvalid_v[p]),
      .rdata  (rdata_v[p])
    );
  end

  assign m0.rvalid = rvalid_v[0];
  assign m0.rdata  = rdata_v[0];
  assign m1.rvalid = rvalid_v[1];
  assign m1.rdata  = rdata_v[1];
endmodule

// File: doc/rom_read_arbiter.md
# rom_read_arbiter

Two-port read arbiter and sequencer for the single-port 1024×32 instruction ROM. It shares one ROM read port between an instruction-fetch requester (port 0) and a debug/display requester (port 1). It drives the ROM's enable and address, tracks each read through the ROM latency with a tag pipeline, and returns the 32-bit word to the requester that issued it. It sits between the ROM instance and its consumers, with one read issued per cycle at full throughput.

## Interface
- READ_LAT, 1, ROM read latency in cycles from the enable-sampling edge to valid douta; legal range 1..4.
- clka  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  port 0 read request; must be held with m0_addr stable until m0_gnt.
- m0_addr  in  10  port 0 word address.
- m0_gnt  out  1  combinational; request accepted this cycle.
- m0_rvalid  out  1  registered; m0_rdata valid this cycle (one-cycle pulse per read).
- m0_rdata  out  32  registered read data; holds its last value between responses.
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata: same as port 0, for port 1.
- rom_ena  out  1  ROM enable; combinational.
- rom_addra  out  10  ROM address; combinational.
- rom_douta  in  32  ROM data out.

## Operation
- Grant:
  - rom_ena = m0_req | m1_req.
  - At most one gnt per cycle. The granted port's addr is muxed to rom_addra.
  - When neither port requests, rom_addra is 0 and both gnt are 0.
- Round-robin:
  - The 1-bit register prio (reset 0) names the preferred port.
  - If both ports request, the preferred port wins. If one requests, it wins.
  - On any grant, prio becomes the non-granted port's index. prio holds when no grant occurs.
- Tag pipeline:
  - The pipeline is READ_LAT stages of {v, id}.
  - Stage 0 loads {rom_ena, granted id} each cycle and shifts every cycle.
  - When the last stage has v=1, the next edge captures rom_douta into m<id>_rdata and raises m<id>_rvalid for one cycle.
  - The other port's rdata and rvalid are unaffected.
- Ordering: responses return in grant order, one per cycle maximum. No backpressure on responses; requesters must accept them.
- Reset values:
  - All gnt, rvalid and rom_ena are 0. All rdata are 0. prio is 0. All tag stages have v=0.
  - Reset mid-operation discards all in-flight reads; no rvalid is produced for them after release.
- Address width: addresses pass through unmodified; 10 bits cover the full ROM. No wrap logic is needed in the arbiter.

## Timing
- A request granted in cycle C produces rvalid high in cycle C+READ_LAT+1, with rdata equal to ROM[addr].
- With READ_LAT=1, the gnt-to-rvalid latency is 2 cycles.
- gnt, rom_ena and rom_addra are combinational from req, addr and prio; there is no added cycle on issue.
- Throughput: a single continuous requester is granted every cycle. Two continuous requesters alternate 0,1,0,1… (the round-robin build starts with 0 after reset).
- Simultaneous events: a new grant, a response delivery and the prio update all happen on the same edge without conflict.
- A port may receive a response while it is also being granted a new read.

## Configuration
- ROM_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority. Port 0 always wins when both ports request. prio is not implemented. Port 1 is granted only in cycles with m0_req=0.
  - Undefined (default): round-robin as described above.
- Latency, tag behaviour and reset are identical in both builds.

## Test plan
- Reset then idle, checked for 10 cycles:
  - All outputs are 0.
  - rst is asserted asynchronously mid-cycle; all outputs go to 0 immediately.
- Port 0 reads, READ_LAT=1:
  - Single m0 request for addr 0x005 -> m0_gnt the same cycle, m0_rvalid 2 cycles later, m0_rdata = ROM[5].
  - Back-to-back requests for addrs 0..7 -> 8 consecutive rvalid pulses carrying ROM[0..7] in order.
- Contention, round-robin build:
  - m0 and m1 request continuously from reset -> grants go 0,1,0,1.
  - Each port receives rvalid every other cycle with correct data. m1 never sees m0's data.
- Contention, fixed-priority build (ROM_ARB_FIXED_PRIO_EN defined):
  - Both ports request for 6 cycles, then m0 drops -> m1 gets no grant for those 6 cycles, then a grant the next cycle.
- Reset with reads in flight, READ_LAT=3:
  - Issue 3 reads, assert rst one cycle after the last grant, then release -> no rvalid for the discarded reads; all rdata = 0.
  - A new read after release completes with the correct data 4 cycles after grant.
- Max address:
  - m1 reads 0x3FF with READ_LAT=2 -> m1_rvalid 3 cycles after grant, data = ROM[1023].
  - m1_rdata holds that value until m1's next response.
